adder_pipelined: RTL and testbench

Parametrised, pipelined add/subtract unit. It splits a `G_DATA_WIDTH`-bit operation into `G_NB_STAGES` equal chunks and ripples the carry between register stages, so wide datapaths close timing at full clock rate. Operands enter and results leave through valid/ready handshakes, which lets the block sit directly between streaming producers and consumers in the datapath. It generalises the combinational adder with subtract mode, carry/borrow-in, signed overflow, pipelining and back-pressure.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/adder_stage.sv | 38 +++
 rtl/adder_pipelined.sv | 162 ++++++++++++++++
 tb/tb_adder_pipelined.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants, types and helpers for the pipelined add/subtract unit.
package adder_pkg;

  localparam logic C_MODE_ADD = 1'b0;
  localparam logic C_MODE_SUB = 1'b1;

  // Control record carried alongside each chunk through the pipeline
  typedef struct packed {
    logic valid;
    logic mode;
    logic sign_x;
    logic sign_y;
  } stage_ctrl_t;

  localparam stage_ctrl_t C_CTRL_IDLE = '{valid: 1'b0, mode: C_MODE_ADD, sign_x: 1'b0, sign_y: 1'b0};

  function automatic int unsigned f_chunk_width(input int unsigned data_width,
                                                input int unsigned nb_stages);
    return data_width / nb_stages;
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One chunk of the pipelined adder: chunk add with carry, registered result,
// carry-out and control record, all advancing on a shared enable.
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned G_CHUNK_WIDTH = 8
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     en,
  input  logic [G_CHUNK_WIDTH-1:0] a,
  input  logic [G_CHUNK_WIDTH-1:0] b,
  input  logic                     cin,
  input  stage_ctrl_t              ctrl_in,
  output logic [G_CHUNK_WIDTH-1:0] s,
  output logic                     cout,
  output stage_ctrl_t              ctrl_out
);

  logic [G_CHUNK_WIDTH:0] sum_c;

  always_comb begin
    sum_c = {1'b0, a} + {1'b0, b} + (G_CHUNK_WIDTH + 1)'(cin);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      s        <= '0;
      cout     <= 1'b0;
      ctrl_out <= C_CTRL_IDLE;
    end else if (en) begin
      s        <= sum_c[G_CHUNK_WIDTH-1:0];
      cout     <= sum_c[G_CHUNK_WIDTH];
      ctrl_out <= ctrl_in;
    end
  end

endmodule

// File: rtl/adder_pipelined.sv
// Pipelined add/subtract unit: carry ripples chunk by chunk across register
// stages, with valid/ready handshakes and a global stall.
module adder_pipelined
  import adder_pkg::*;
#(
  parameter int unsigned G_DATA_WIDTH = 32,
  parameter int unsigned G_NB_STAGES  = 4
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [G_DATA_WIDTH-1:0] X,
  input  logic [G_DATA_WIDTH-1:0] Y,
  input  logic                    MODE_SUB,
  input  logic                    CARRY_IN,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [G_DATA_WIDTH:0]   SUM,
  output logic                    OVERFLOW
);

  localparam int unsigned W  = G_DATA_WIDTH;
  localparam int unsigned N  = G_NB_STAGES;
  localparam int unsigned CW = f_chunk_width(G_DATA_WIDTH, G_NB_STAGES);
  localparam int unsigned L  = N - 1;

  if (N == 0 || (W % N) != 0) begin : g_bad_params
    $error("adder_pipelined: G_DATA_WIDTH must be a non-zero multiple of G_NB_STAGES");
  end

  logic        en;
  logic [W-1:0] y_eff_c;
  logic        cin_eff_c;
  stage_ctrl_t ctrl_in_c;

  logic [W-1:0] x_q;
  logic [W-1:0] y_q;
  logic        cin_q;
  stage_ctrl_t ctrl_q;

  // Subtract is folded into the operand: X + ~Y + !borrow_in
  always_comb begin
    en        = !OUT_VALID || OUT_READY;
    y_eff_c   = (MODE_SUB == C_MODE_SUB) ? ~Y : Y;
    cin_eff_c = CARRY_IN ^ (MODE_SUB == C_MODE_SUB);
    ctrl_in_c = '{valid: IN_VALID, mode: MODE_SUB, sign_x: X[W-1], sign_y: y_eff_c[W-1]};
  end

  assign IN_READY = en;

  // Operand capture register; the accept edge loads it
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      x_q    <= '0;
      y_q    <= '0;
      cin_q  <= 1'b0;
      ctrl_q <= C_CTRL_IDLE;
    end else if (en) begin
      x_q    <= X;
      y_q    <= y_eff_c;
      cin_q  <= cin_eff_c;
      ctrl_q <= ctrl_in_c;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [CW-1:0]       a;
    logic [CW-1:0]       b;
    logic                cin;
    stage_ctrl_t         ci;
    logic [CW-1:0]       s;
    logic                cout;
    stage_ctrl_t         co;
    logic [(k+1)*CW-1:0] lo;

    if (k == 0) begin : g_first
      always_comb begin
        a   = x_q[CW-1:0];
        b   = y_q[CW-1:0];
        cin = cin_q;
        ci  = ctrl_q;
      end
    end else begin : g_next
      always_comb begin
        a   = g_stage[k-1].g_skew.xu[CW-1:0];
        b   = g_stage[k-1].g_skew.yu[CW-1:0];
        cin = g_stage[k-1].cout;
        ci  = g_stage[k-1].co;
      end
    end

    adder_stage #(
      .G_CHUNK_WIDTH(CW)
    ) u_stage (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .en      (en),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .ctrl_in (ci),
      .s       (s),
      .cout    (cout),
      .ctrl_out(co)
    );

    // Upper operand chunks not yet consumed, skewed alongside this stage
    if (k < N - 1) begin : g_skew
      logic [(N-1-k)*CW-1:0] xu;
      logic [(N-1-k)*CW-1:0] yu;

      if (k == 0) begin : g_src
        always_ff @(posedge CLOCK) begin
          if (RESET) begin
            xu <= '0;
            yu <= '0;
          end else if (en) begin
            xu <= x_q[W-1:CW];
            yu <= y_q[W-1:CW];
          end
        end
      end else begin : g_src
        always_ff @(posedge CLOCK) begin
          if (RESET) begin
            xu <= '0;
            yu <= '0;
          end else if (en) begin
            xu <= g_stage[k-1].g_skew.xu[(N-k)*CW-1:CW];
            yu <= g_stage[k-1].g_skew.yu[(N-k)*CW-1:CW];
          end
        end
      end
    end

    // Lower result chunks delayed to line up with this stage's chunk
    if (k == 0) begin : g_lo
      always_comb lo = s;
    end else begin : g_lo
      logic [k*CW-1:0] lr;

      always_ff @(posedge CLOCK) begin
        if (RESET) begin
          lr <= '0;
        end else if (en) begin
          lr <= g_stage[k-1].lo;
        end
      end

      always_comb lo = {s, lr};
    end
  end

  // Carry is inverted into a borrow in subtract mode
  always_comb begin
    OUT_VALID = g_stage[L].co.valid;
    SUM       = {g_stage[L].cout ^ g_stage[L].co.mode, g_stage[L].lo};
    OVERFLOW  = (g_stage[L].co.sign_x == g_stage[L].co.sign_y) &&
                (g_stage[L].lo[W-1] != g_stage[L].co.sign_x);
  end

endmodule

// File: tb/tb_adder_pipelined.sv
// Directed and short randomised checks of adder_pipelined (32 bits, 4 stages).
module tb_adder_pipelined;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] X;
  logic [31:0] Y;
  logic        MODE_SUB;
  logic        CARRY_IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [32:0] SUM;
  logic        OVERFLOW;

  int checks   = 0;
  int failures = 0;

  adder_pipelined #(
    .G_DATA_WIDTH(32),
    .G_NB_STAGES (4)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .X        (X),
    .Y        (Y),
    .MODE_SUB (MODE_SUB),
    .CARRY_IN (CARRY_IN),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .SUM      (SUM),
    .OVERFLOW (OVERFLOW)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic m, input logic c);
    logic [32:0] r;
    logic        o;
    if (!m) begin
      r = {1'b0, x} + {1'b0, y} + 33'(c);
      o = (x[31] == y[31]) && (r[31] != x[31]);
    end else begin
      r = {1'b0, x} - {1'b0, y} - 33'(c);
      o = (x[31] != y[31]) && (r[31] != x[31]);
    end
    return {o, r};
  endfunction

  // Single beat: accept, measure latency, check result, then pop
  task automatic send_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic m, input logic c,
                            input logic [32:0] exp_sum, input logic exp_ovf);
    int lat;
    X = x; Y = y; MODE_SUB = m; CARRY_IN = c; IN_VALID = 1'b1; OUT_READY = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(IN_READY), 64'd1);
    tick();
    IN_VALID = 1'b0; X = 32'hDEADBEEF; Y = 32'h5A5A5A5A; MODE_SUB = ~m; CARRY_IN = ~c;
    lat = 0;
    while (!OUT_VALID && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_sum"}, 64'(SUM), 64'(exp_sum));
    chk({tag, "_ovf"}, 64'(OVERFLOW), 64'(exp_ovf));
    tick();
    chk({tag, "_popped"}, 64'(OUT_VALID), 64'd0);
  endtask

  initial begin
    int          sent;
    int          rcv;
    int          stalls;
    int          seen;
    logic        prev_stall;
    logic [32:0] held;
    logic [33:0] q[$];
    logic [33:0] e;

    // Reset with beats offered
    RESET = 1'b1; IN_VALID = 1'b1; X = 32'd5; Y = 32'd7; MODE_SUB = 1'b0; CARRY_IN = 1'b0;
    OUT_READY = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_sum", 64'(SUM), 64'd0);
    chk("rst_ovf", 64'(OVERFLOW), 64'd0);
    chk("rst_in_ready", 64'(IN_READY), 64'd1);
    RESET = 1'b0; IN_VALID = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (OUT_VALID) seen++;
    end
    chk("rst_no_output", 64'(seen), 64'd0);

    // Directed vectors
    send_check("ripple",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 33'h1_00000000, 1'b0);
    send_check("sub_0m1",  32'h00000000, 32'h00000001, 1'b1, 1'b0, 33'h1_FFFFFFFF, 1'b0);
    send_check("add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 33'h0_80000000, 1'b1);
    send_check("sub_ovf",  32'h80000000, 32'h00000001, 1'b1, 1'b0, 33'h0_7FFFFFFF, 1'b1);
    send_check("add_cin",  32'h12345678, 32'h11111111, 1'b0, 1'b1, 33'h0_2345678A, 1'b0);
    send_check("sub_bin",  32'h0000000A, 32'h00000003, 1'b1, 1'b1, 33'h0_00000006, 1'b0);
    send_check("add_negov",32'h80000000, 32'h80000000, 1'b0, 1'b0, 33'h1_00000000, 1'b1);

    // Back-pressure: 8 beats X=i, Y=2i, OUT_READY low for 3 cycles mid-stream
    sent = 0; rcv = 0; stalls = 0; prev_stall = 1'b0; held = '0;
    MODE_SUB = 1'b0; CARRY_IN = 1'b0;
    for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
      OUT_READY = !(cyc >= 6 && cyc < 9);
      IN_VALID  = (sent < 8);
      X = 32'(sent); Y = 32'(2 * sent);
      #1;
      if (OUT_VALID && !OUT_READY) begin
        stalls++;
        chk("bp_in_ready_stalled", 64'(IN_READY), 64'd0);
        if (prev_stall) chk("bp_sum_stable", 64'(SUM), 64'(held));
        held = SUM;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (OUT_VALID && OUT_READY) begin
        chk("bp_sum", 64'(SUM), 64'(3 * rcv));
        rcv++;
      end
      if (IN_VALID && IN_READY) sent++;
      tick();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    chk("bp_sent", 64'(sent), 64'd8);
    chk("bp_received", 64'(rcv), 64'd8);
    chk("bp_stall_cycles", 64'(stalls), 64'd3);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (OUT_VALID) seen++;
    end
    chk("bp_no_duplicate", 64'(seen), 64'd0);

    // Reset mid-flight discards in-flight beats
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1; X = 32'(i + 40); Y = 32'd1; MODE_SUB = 1'b0; CARRY_IN = 1'b0;
      tick();
    end
    IN_VALID = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (OUT_VALID) seen++;
      tick();
    end
    chk("midrst_discarded", 64'(seen), 64'd0);
    send_check("midrst_fresh", 32'd100, 32'd23, 1'b0, 1'b0, 33'd123, 1'b0);

    // Randomised traffic against a reference model
    for (int cyc = 0; cyc < 600; cyc++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      X = $urandom(); Y = $urandom();
      MODE_SUB = 1'($urandom_range(0, 1)); CARRY_IN = 1'($urandom_range(0, 1));
      #1;
      if (OUT_VALID && OUT_READY) begin
        chk("rnd_queue_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rnd_result", 64'({OVERFLOW, SUM}), 64'(e));
        end
      end
      if (IN_VALID && IN_READY) q.push_back(model(X, Y, MODE_SUB, CARRY_IN));
      tick();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      #1;
      if (OUT_VALID) begin
        e = q.pop_front();
        chk("rnd_drain", 64'({OVERFLOW, SUM}), 64'(e));
      end
      tick();
    end
    chk("rnd_all_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
